// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: command, response and external 8-bit ALU signals of alu_seq_ctrl.
// Optional cmd_use_acc is present only when ALU_SEQ_CTRL_ACC_EN is defined.
interface alu_seq_ctrl_if;
    logic        cmd_valid, cmd_ready, cmd_wide;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b;
`ifdef ALU_SEQ_CTRL_ACC_EN
    logic        cmd_use_acc;
`endif
    logic        rsp_valid, rsp_ready, rsp_carry, rsp_zero;
    logic [15:0] rsp_data;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_cout;
    modport slave (
`ifdef ALU_SEQ_CTRL_ACC_EN
        input  cmd_use_acc,
`endif
        input  cmd_valid, cmd_wide, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_cout,
        output cmd_ready, rsp_valid, rsp_carry, rsp_zero, rsp_data, alu_a, alu_b, alu_op, alu_cin
    );
    modport master (
`ifdef ALU_SEQ_CTRL_ACC_EN
        output cmd_use_acc,
`endif
        output cmd_valid, cmd_wide, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_cout,
        input  cmd_ready, rsp_valid, rsp_carry, rsp_zero, rsp_data, alu_a, alu_b, alu_op, alu_cin
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences 8/16-bit operations over an external 8-bit ALU (one or two passes).
// ALU_SEQ_CTRL_ACC_EN adds an accumulator that can replace the A operand.
module alu_seq_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic        r_wide, r_carry, r_zero;
    logic [15:0] r_a, r_b, r_res;
    logic        w_arith;
    logic [15:0] w_a_src;
    assign w_arith = r_op[2:1] == 2'b00;
`ifdef ALU_SEQ_CTRL_ACC_EN
    logic [15:0] r_acc;
    assign w_a_src = bus.cmd_use_acc ? r_acc : bus.cmd_a;
    always_ff @(posedge clk)
        if (!rst_n)
            r_acc <= 16'h0000;
        else if (r_state == DONE && bus.rsp_ready)
            r_acc <= r_res;
`else
    assign w_a_src = bus.cmd_a;
`endif
    always_ff @(posedge clk)
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = bus.cmd_valid ? LO : IDLE;
            LO:   w_next = r_wide ? HI : DONE;
            HI:   w_next = DONE;
            DONE: w_next = bus.rsp_ready ? IDLE : DONE;
        endcase
    end
    always_comb begin
        bus.cmd_ready = r_state == IDLE;
        bus.rsp_valid = r_state == DONE;
        bus.rsp_data  = r_res;
        bus.rsp_carry = r_carry;
        bus.rsp_zero  = r_zero;
        bus.alu_a     = r_state == LO ? r_a[7:0] : r_state == HI ? r_a[15:8] : 8'h00;
        bus.alu_b     = r_state == LO ? r_b[7:0] : r_state == HI ? r_b[15:8] : 8'h00;
        bus.alu_op    = (r_state == LO || r_state == HI) ? r_op : 3'b000;
        bus.alu_cin   = r_state == LO ? r_op[0] : r_state == HI ? (w_arith ? r_carry : r_op[0]) : 1'b0;
    end
    // Zero flag is registered per pass so it reads 0 out of reset rather than reflecting r_res==0.
    always_ff @(posedge clk)
        if (!rst_n) begin
            r_op    <= 3'b000;
            r_wide  <= 1'b0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_res   <= 16'h0000;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == IDLE && bus.cmd_valid) begin
            r_op   <= bus.cmd_op;
            r_wide <= bus.cmd_wide;
            r_a    <= w_a_src;
            r_b    <= bus.cmd_b;
        end else if (r_state == LO) begin
            r_res   <= {8'h00, bus.alu_out};
            r_carry <= bus.alu_cout;
            r_zero  <= bus.alu_out == 8'h00;
        end else if (r_state == HI) begin
            r_res[15:8] <= bus.alu_out;
            r_carry     <= bus.alu_cout;
            r_zero      <= bus.alu_out == 8'h00 && r_res[7:0] == 8'h00;
        end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench with a behavioural 8-bit ALU model.
// Exercises the accumulator path when ALU_SEQ_CTRL_ACC_EN is defined.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    alu_seq_ctrl_if ifc ();
    alu_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    always #5 clk = ~clk;
    logic [8:0] alu_sum;
    always_comb begin
        case (ifc.alu_op)
            3'b000:  alu_sum = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + 9'(ifc.alu_cin);
            3'b001:  alu_sum = {1'b0, ifc.alu_a} + {1'b0, ~ifc.alu_b} + 9'(ifc.alu_cin);
            3'b010:  alu_sum = {1'b0, ifc.alu_a & ifc.alu_b};
            3'b011:  alu_sum = {1'b0, ifc.alu_a | ifc.alu_b};
            3'b100:  alu_sum = {1'b0, ifc.alu_a ^ ifc.alu_b};
            default: alu_sum = {1'b0, ifc.alu_a};
        endcase
        ifc.alu_out  = alu_sum[7:0];
        ifc.alu_cout = alu_sum[8];
    end

    task automatic run_cmd(input logic [2:0] op, input logic w, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [15:0] d, output logic c, output logic z);
        int n = 0;
        ifc.cmd_op = op; ifc.cmd_wide = w; ifc.cmd_a = a; ifc.cmd_b = b;
        ifc.cmd_valid = 1'b1; ifc.rsp_ready = 1'b1;
        while (!ifc.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        lat = 1;
        while (!ifc.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        d = ifc.rsp_data; c = ifc.rsp_carry; z = ifc.rsp_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", ifc.rsp_valid); end
        n_chk++; if (ifc.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset rsp_data: got %h want 0000", ifc.rsp_data); end
        n_chk++; if ({ifc.rsp_carry, ifc.rsp_zero} !== 2'b00) begin n_fail++; $display("FAIL reset flags: got %b want 00", {ifc.rsp_carry, ifc.rsp_zero}); end
        n_chk++; if ({ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.alu_cin} !== 20'h0) begin n_fail++; $display("FAIL reset alu_drive: got %h want 0", {ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.alu_cin}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready: got %b want 1", ifc.cmd_ready); end
    endtask

    task automatic test_narrow_add;
        int lat; logic [15:0] d; logic c, z;
        run_cmd(3'b000, 1'b0, 16'd95, 16'd14, lat, d, c, z);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL narrow_add latency: got %0d want 2", lat); end
        n_chk++; if (d !== 16'd109) begin n_fail++; $display("FAIL narrow_add data: got %h want %h", d, 16'd109); end
        n_chk++; if ({c, z} !== 2'b00) begin n_fail++; $display("FAIL narrow_add flags: got %b want 00", {c, z}); end
        run_cmd(3'b000, 1'b0, 16'hAB80, 16'hCD80, lat, d, c, z);
        n_chk++; if (d !== 16'h0000) begin n_fail++; $display("FAIL narrow_ovf data: got %h want 0000", d); end
        n_chk++; if ({c, z} !== 2'b11) begin n_fail++; $display("FAIL narrow_ovf flags: got %b want 11", {c, z}); end
        run_cmd(3'b001, 1'b0, 16'd3, 16'd4, lat, d, c, z);
        n_chk++; if ({d, c, z} !== {16'h00FF, 2'b00}) begin n_fail++; $display("FAIL narrow_sub result: got %h %b%b want 00ff 00", d, c, z); end
    endtask

    task automatic test_wide_add;
        ifc.cmd_op = 3'b000; ifc.cmd_wide = 1'b1; ifc.cmd_a = 16'h00FF; ifc.cmd_b = 16'h0001;
        ifc.cmd_valid = 1'b1; ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        n_chk++; if (ifc.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wide_add lo cmd_ready: got %b want 0", ifc.cmd_ready); end
        n_chk++; if ({ifc.alu_a, ifc.alu_b, ifc.alu_cin} !== {8'hFF, 8'h01, 1'b0}) begin n_fail++; $display("FAIL wide_add lo drive: got %h %h %b want ff 01 0", ifc.alu_a, ifc.alu_b, ifc.alu_cin); end
        @(posedge clk); #1;
        n_chk++; if ({ifc.alu_a, ifc.alu_b, ifc.alu_cin} !== {8'h00, 8'h00, 1'b1}) begin n_fail++; $display("FAIL wide_add hi drive: got %h %h %b want 00 00 1", ifc.alu_a, ifc.alu_b, ifc.alu_cin); end
        n_chk++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wide_add early rsp_valid: got %b want 0", ifc.rsp_valid); end
        @(posedge clk); #1;
        n_chk++; if (ifc.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wide_add latency rsp_valid: got %b want 1", ifc.rsp_valid); end
        n_chk++; if ({ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero} !== {16'h0100, 2'b00}) begin n_fail++; $display("FAIL wide_add result: got %h %b%b want 0100 00", ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero); end
        n_chk++; if ({ifc.alu_a, ifc.alu_op, ifc.alu_cin} !== 12'h0) begin n_fail++; $display("FAIL wide_add done drive: got %h want 0", {ifc.alu_a, ifc.alu_op, ifc.alu_cin}); end
        @(posedge clk); #1;
    endtask

    task automatic test_wide_ops;
        int lat; logic [15:0] d; logic c, z;
        run_cmd(3'b001, 1'b1, 16'h1234, 16'h1234, lat, d, c, z);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL wide_sub latency: got %0d want 3", lat); end
        n_chk++; if ({d, c, z} !== {16'h0000, 2'b11}) begin n_fail++; $display("FAIL wide_sub result: got %h %b%b want 0000 11", d, c, z); end
        run_cmd(3'b010, 1'b1, 16'hF0F0, 16'h0FF0, lat, d, c, z);
        n_chk++; if ({d, c, z} !== {16'h00F0, 2'b00}) begin n_fail++; $display("FAIL wide_and result: got %h %b%b want 00f0 00", d, c, z); end
    endtask

    task automatic test_backpressure;
        int n = 0;
        ifc.cmd_op = 3'b100; ifc.cmd_wide = 1'b0; ifc.cmd_a = 16'h0010; ifc.cmd_b = 16'h0020;
        ifc.cmd_valid = 1'b1; ifc.rsp_ready = 1'b0;
        @(posedge clk); #1;
        ifc.cmd_op = 3'b001; ifc.cmd_a = 16'h0005; ifc.cmd_b = 16'h0005;
        while (!ifc.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero} !== {2'b10, 16'h0030, 2'b00}) begin
                n_fail++; $display("FAIL backpressure hold %0d: got v%b r%b %h %b%b want v1 r0 0030 00", i, ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero); end
            @(posedge clk); #1;
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({ifc.rsp_valid, ifc.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL backpressure release: got v%b r%b want v0 r1", ifc.rsp_valid, ifc.cmd_ready); end
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({ifc.rsp_valid, ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero} !== {1'b1, 16'h0000, 2'b11}) begin
            n_fail++; $display("FAIL backpressure second: got v%b %h %b%b want v1 0000 11", ifc.rsp_valid, ifc.rsp_data, ifc.rsp_carry, ifc.rsp_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [15:0] d; logic c, z;
        int seen = 0;
        ifc.cmd_op = 3'b000; ifc.cmd_wide = 1'b1; ifc.cmd_a = 16'h1111; ifc.cmd_b = 16'h2222;
        ifc.cmd_valid = 1'b1; ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++; if ({ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_data} !== {2'b01, 16'h0000}) begin
            n_fail++; $display("FAIL reset_mid state: got v%b r%b %h want v0 r1 0000", ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_data); end
        repeat (4) begin @(posedge clk); #1; if (ifc.rsp_valid) seen++; end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL reset_mid stray response: got %0d want 0", seen); end
        run_cmd(3'b000, 1'b0, 16'd20, 16'd22, lat, d, c, z);
        n_chk++; if ({lat[3:0], d, c, z} !== {4'd2, 16'd42, 2'b00}) begin n_fail++; $display("FAIL reset_mid next cmd: got lat%0d %h %b%b want lat2 002a 00", lat, d, c, z); end
    endtask

`ifdef ALU_SEQ_CTRL_ACC_EN
    task automatic test_acc;
        int lat; logic [15:0] d; logic c, z;
        run_cmd(3'b000, 1'b1, 16'h00FF, 16'h0001, lat, d, c, z);
        n_chk++; if (d !== 16'h0100) begin n_fail++; $display("FAIL acc first: got %h want 0100", d); end
        ifc.cmd_use_acc = 1'b1;
        run_cmd(3'b000, 1'b1, 16'hFFFF, 16'h0001, lat, d, c, z);
        ifc.cmd_use_acc = 1'b0;
        n_chk++; if ({d, c, z} !== {16'h0101, 2'b00}) begin n_fail++; $display("FAIL acc use: got %h %b%b want 0101 00", d, c, z); end
    endtask
`endif

    initial begin
        ifc.cmd_valid = 1'b0; ifc.cmd_op = 3'b000; ifc.cmd_wide = 1'b0;
        ifc.cmd_a = 16'h0000; ifc.cmd_b = 16'h0000; ifc.rsp_ready = 1'b1;
`ifdef ALU_SEQ_CTRL_ACC_EN
        ifc.cmd_use_acc = 1'b0;
`endif
        test_reset;
        test_narrow_add;
        test_wide_add;
        test_wide_ops;
        test_backpressure;
        test_reset_mid;
`ifdef ALU_SEQ_CTRL_ACC_EN
        test_acc;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: cmd_valid  input  1  command present.
REQ-004 SHALL have: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-005 SHALL have: cmd_op  input  3  ALU opcode, same encoding as alu op.
REQ-006 SHALL have: cmd_wide  input  1  1 = 16-bit operation over two ALU passes, 0 = 8-bit.
REQ-007 SHALL have: cmd_a, cmd_b  input  16  operands (bits [15:8] ignored when cmd_wide=0).
REQ-008 SHALL have: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  16; rsp_carry  output  1; rsp_zero  output  1.
REQ-009 SHALL have: alu_a, alu_b  output  8; alu_op  output  3; alu_cin  output  1  drive the external 8-bit ALU.
REQ-010 SHALL have: alu_out  input  8; alu_cout  input  1  results from the external 8-bit ALU (combinational, same cycle).

Function
REQ-011 ALU contract: op 000 = A+B+cin, op 001 = A+~B+cin (subtract, cin=1 means no borrow-in); all other ops use cin=op[0] and are bytewise.
REQ-012 FSM states SHALL be IDLE, LO, HI, DONE; cmd_ready=1 only in IDLE.
REQ-013 IDLE: on handshake, latch op/wide/a/b, go to LO; otherwise stay.
REQ-014 LO: alu_a=a[7:0], alu_b=b[7:0], alu_op=op, alu_cin=op[0]; capture alu_out into res[7:0] and alu_cout into carry; go to HI if wide, else DONE.
REQ-015 HI: alu_a=a[15:8], alu_b=b[15:8], alu_op=op; alu_cin = captured carry for op 000/001, else op[0]; capture alu_out into res[15:8] and alu_cout into carry; go to DONE.
REQ-016 Narrow result SHALL have rsp_data[15:8]=8'h00; rsp_carry = carry of the final pass.
REQ-017 rsp_zero SHALL be 1 iff all valid result bits (8 narrow, 16 wide) are zero.
REQ-018 DONE: rsp_valid=1, rsp_data/carry/zero held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-019 Latency from accept edge to rsp_valid: 2 cycles narrow, 3 cycles wide; throughput one command per 3 (narrow) / 4 (wide) cycles with rsp_ready=1.
REQ-020 In IDLE and DONE, alu_a/alu_b/alu_op/alu_cin SHALL be 0.
REQ-021 Commands presented while cmd_ready=0 SHALL NOT be latched; the command SHALL be held by the source.

Reset
REQ-022 With rst_n=0 at a clock edge: state IDLE, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, internal latches 0; cmd_ready=1 on the following cycle.
REQ-023 Reset in LO, HI or DONE SHALL abort the operation with no response emitted.

Configuration
REQ-024 Macro ALU_SEQ_CTRL_ACC_EN: when defined, adds input cmd_use_acc (1 bit) and a 16-bit accumulator loaded with rsp_data at every response handshake (reset 0); when cmd_use_acc=1 at accept, the accumulator replaces cmd_a.
REQ-025 Without ALU_SEQ_CTRL_ACC_EN: no cmd_use_acc port, no accumulator; A operand always cmd_a.

Verification
REQ-026 Narrow add: a=95, b=14, op=000 -> rsp_data=16'd109, carry=0, zero=0, rsp_valid 2 cycles after accept.
REQ-027 Wide add: a=16'h00FF, b=16'h0001, op=000 -> rsp_data=16'h0100, carry=0, zero=0 (low-byte carry propagated), rsp_valid 3 cycles after accept.
REQ-028 Wide subtract: a=b=16'h1234, op=001 -> rsp_data=16'h0000, carry=1, zero=1.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp fields stable, cmd_ready=0, second pending command accepted only after response handshake.
REQ-030 Reset mid-operation: rst_n=0 during HI -> next cycle state IDLE, rsp_valid=0, no response emitted; next command completes normally.
REQ-031 With ALU_SEQ_CTRL_ACC_EN: wide add producing 16'h0100, then cmd_use_acc=1, b=16'h0001, op=000 -> rsp_data=16'h0101.
